sram_confreg_resp: RTL and testbench

Responder on the far side of the CPU's data SRAM interface (`data_sram_en/wen/addr/wdata/rdata`). Decodes each access either to an internal word-organised RAM or to a small configuration-register window (free-running timer, LED, 7-seg number, switch input). Returns read data with a fixed one-cycle latency, which matches the MEM-stage capture of `data_sram_rdata`. Sits in the SoC top next to the CPU and replaces the external data SRAM model for simulation and FPGA bring-up.

---
 rtl/sram_confreg_resp.sv | 135 +++++++++++++
 tb/tb_sram_confreg_resp.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sram_confreg_resp.sv
// Data-SRAM responder: word RAM plus a config-register window (timer, LED, 7-seg, switches).
// Read-first, one-cycle registered read latency, byte-merged writes, synchronous active-low reset.
module sram_confreg_resp #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic [31:0] num_data,
    input  logic [7:0]  switch
);

    // Word offsets (byte offset >> 2) inside the config window
    localparam logic [13:0] OFF_TIMER  = 14'h3800;
    localparam logic [13:0] OFF_LED    = 14'h3c00;
    localparam logic [13:0] OFF_NUM    = 14'h3c04;
    localparam logic [13:0] OFF_SWITCH = 14'h3c08;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  wen
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = wen[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]       ram_q [2**RAM_AW];
    logic [31:0]       rdata_q;
    logic [31:0]       timer_q, timer_d;
    logic [15:0]       led_q, led_d;
    logic [31:0]       num_q, num_d;
    logic [7:0]        sw_meta_q, sw_sync_q;

    logic              conf_hit_s, wr_s;
    logic              sel_timer_s, sel_led_s, sel_num_s, sel_sw_s;
    logic [RAM_AW-1:0] ram_idx_s;
    logic [31:0]       conf_rdata_s, led_merge_s;
    logic              unused_s;

    assign unused_s  = ^data_sram_addr[1:0];
    assign ram_idx_s = data_sram_addr[RAM_AW+1:2];

    // Address decode and config read mux
    always_comb begin
        conf_hit_s   = (data_sram_addr[31:16] == CONF_BASE[31:16]);
        wr_s         = data_sram_en && (data_sram_wen != 4'h0);
        sel_timer_s  = 1'b0;
        sel_led_s    = 1'b0;
        sel_num_s    = 1'b0;
        sel_sw_s     = 1'b0;
        conf_rdata_s = 32'h0000_0000;
        case (data_sram_addr[15:2])
            OFF_TIMER: begin
                sel_timer_s  = conf_hit_s;
                conf_rdata_s = timer_q;
            end
            OFF_LED: begin
                sel_led_s    = conf_hit_s;
                conf_rdata_s = {16'h0000, led_q};
            end
            OFF_NUM: begin
                sel_num_s    = conf_hit_s;
                conf_rdata_s = num_q;
            end
            OFF_SWITCH: begin
                sel_sw_s     = conf_hit_s;
                conf_rdata_s = {24'h00_0000, sw_sync_q};
            end
            default: conf_rdata_s = 32'h0000_0000;
        endcase
    end

    // Next-state for the config registers; a timer write replaces that cycle's increment
    always_comb begin
        led_merge_s = byte_merge({16'h0000, led_q}, data_sram_wdata, data_sram_wen);
        if (wr_s && sel_timer_s) begin
            timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
        end else begin
            timer_d = timer_q + 32'd1;
        end
        if (wr_s && sel_led_s) begin
            led_d = led_merge_s[15:0];
        end else begin
            led_d = led_q;
        end
        if (wr_s && sel_num_s) begin
            num_d = byte_merge(num_q, data_sram_wdata, data_sram_wen);
        end else begin
            num_d = num_q;
        end
    end

    // RAM array: contents survive reset, but a write presented during reset is dropped
    always_ff @(posedge clk) begin
        if (resetn && wr_s && !conf_hit_s) begin
            ram_q[ram_idx_s] <= byte_merge(ram_q[ram_idx_s], data_sram_wdata, data_sram_wen);
        end
    end

    // Registered read-first data, config registers and switch synchronizer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q   <= 32'h0000_0000;
            timer_q   <= 32'h0000_0000;
            led_q     <= 16'h0000;
            num_q     <= 32'h0000_0000;
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
        end else begin
            if (data_sram_en) begin
                rdata_q <= conf_hit_s ? conf_rdata_s : ram_q[ram_idx_s];
            end
            timer_q   <= timer_d;
            led_q     <= led_d;
            num_q     <= num_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule

// File: tb/tb_sram_confreg_resp.sv
// Scoreboard bench for sram_confreg_resp: directed accesses push expected read data,
// a negedge monitor pops and compares whenever a checked response is due.
module tb_sram_confreg_resp;

    localparam logic [31:0] A_TIMER  = 32'hbfaf_e000;
    localparam logic [31:0] A_LED    = 32'hbfaf_f000;
    localparam logic [31:0] A_NUM    = 32'hbfaf_f010;
    localparam logic [31:0] A_SWITCH = 32'hbfaf_f020;
    localparam logic [31:0] A_UNMAP  = 32'hbfaf_f030;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr, wdata, rdata, num_data;
    logic [15:0] led;
    logic [7:0]  sw;

    logic        chk_req;
    logic        resp_due;
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    sram_confreg_resp dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .num_data        (num_data),
        .switch          (sw)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // A checked access accepted at this edge has its data visible after the edge
    always @(posedge clk) resp_due <= en && chk_req && resetn;

    // Monitor: compare each due response with the head of the scoreboard
    always @(negedge clk) begin
        if (resp_due) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: got rdata=%h with no expectation", rdata);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rdata !== e) begin
                    failures++;
                    $display("FAIL %s: rdata=%h expected=%h", n, rdata, e);
                end
            end
        end
    end

    task automatic acc(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input logic chk, input logic [31:0] e, input string n);
        en = 1'b1; wen = w; addr = a; wdata = d; chk_req = chk;
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(n);
        end
        @(posedge clk); #1;
        en = 1'b0; wen = 4'h0; chk_req = 1'b0;
    endtask

    task automatic idle();
        en = 1'b0; wen = 4'h0; chk_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic direct(input string n, input logic [31:0] got, input logic [31:0] e);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", n, got, e);
        end
    endtask

    initial begin
        resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        sw = 8'h00; chk_req = 1'b0; resp_due = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        direct("reset_rdata", rdata, 32'h0);
        direct("reset_led", {16'h0, led}, 32'h0);
        direct("reset_num", num_data, 32'h0);
        resetn = 1'b1;

        // Timer: cycle 0 after release reads 0, so cycle 10 reads 10
        repeat (10) idle();
        acc(4'h0, A_TIMER, 32'h0, 1'b1, 32'd10, "timer_cycle10");
        acc(4'hf, A_TIMER, 32'hffff_fffe, 1'b1, 32'd11, "timer_write_old");
        acc(4'h0, A_TIMER, 32'h0, 1'b1, 32'hffff_fffe, "timer_ow_0");
        acc(4'h0, A_TIMER, 32'h0, 1'b1, 32'hffff_ffff, "timer_ow_1");
        acc(4'h0, A_TIMER, 32'h0, 1'b1, 32'h0000_0000, "timer_wrap");

        // RAM full word, byte merge, read-first, index aliasing
        acc(4'hf, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0, "");
        acc(4'h0, 32'h0000_0040, 32'h0, 1'b1, 32'h1234_5678, "ram_word");
        acc(4'h5, 32'h0000_0040, 32'hffff_ffff, 1'b1, 32'h1234_5678, "ram_read_first");
        acc(4'h0, 32'h0000_0040, 32'h0, 1'b1, 32'h12ff_56ff, "ram_merge");
        acc(4'h0, 32'h0000_4040, 32'h0, 1'b1, 32'h12ff_56ff, "ram_alias");
        acc(4'h0, 32'h0000_0043, 32'h0, 1'b1, 32'h12ff_56ff, "ram_low_bits_ignored");

        // LED and NUM
        acc(4'hf, A_LED, 32'habcd_1234, 1'b1, 32'h0, "led_write_old");
        direct("led_port", {16'h0, led}, 32'h0000_1234);
        acc(4'h0, A_LED, 32'h0, 1'b1, 32'h0000_1234, "led_readback");
        acc(4'h3, A_NUM, 32'hdead_beef, 1'b1, 32'h0, "num_write_old");
        direct("num_port", num_data, 32'h0000_beef);
        acc(4'h0, A_NUM, 32'h0, 1'b1, 32'h0000_beef, "num_readback");
        idle();
        direct("rdata_hold", rdata, 32'h0000_beef);

        // Switch through the synchronizer, unmapped offset
        sw = 8'ha5;
        idle();
        idle();
        acc(4'h0, A_SWITCH, 32'h0, 1'b1, 32'h0000_00a5, "switch_read");
        acc(4'hf, A_UNMAP, 32'h0000_0001, 1'b1, 32'h0, "unmapped_write");
        acc(4'h0, A_UNMAP, 32'h0, 1'b1, 32'h0, "unmapped_read");

        // Reset mid-operation with TIMER at 500 and a pending LED write
        acc(4'hf, A_TIMER, 32'd500, 1'b0, 32'h0, "");
        resetn = 1'b0;
        acc(4'hf, A_LED, 32'h0000_0077, 1'b0, 32'h0, "");
        direct("rst_led", {16'h0, led}, 32'h0);
        direct("rst_rdata", rdata, 32'h0);
        resetn = 1'b1;
        acc(4'h0, A_TIMER, 32'h0, 1'b1, 32'd0, "rst_timer_0");
        acc(4'h0, A_TIMER, 32'h0, 1'b1, 32'd1, "rst_timer_1");
        acc(4'h0, A_LED, 32'h0, 1'b1, 32'h0, "rst_led_read");
        acc(4'h0, 32'h0000_0040, 32'h0, 1'b1, 32'h12ff_56ff, "rst_ram_kept");
        idle();
        idle();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
